csidh_exponent_scheduler: RTL and testbench

Constant-time sequencer for the CSIDH group-action loop. It latches the 296-bit private exponent vector (74 signed 4-bit exponents) and validates every entry. It then issues exactly NUM_PRIMES*MAX_E isogeny commands to the isogeny/xMUL engine in a fixed round-major order, marking each command as real or dummy. Command count and order are independent of the key, so the datapath's timing does not leak the secret.

---
 rtl/csidh_pkg.sv | 20 ++
 rtl/csidh_exp_decode.sv | 19 +
 rtl/csidh_exponent_scheduler.sv | 159 +++++++++++++++
 tb/tb_csidh_exponent_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/csidh_pkg.sv
// Shared constants and state encoding for the CSIDH exponent scheduler and its engine.
package csidh_pkg;

    localparam int unsigned NUM_PRIMES = 74;
    localparam int unsigned EXP_W      = 4;
    localparam int unsigned MAX_E      = 5;
    localparam int unsigned IDX_W      = 7;
    localparam int unsigned RND_W      = 3;
    localparam int unsigned KEY_W      = EXP_W * NUM_PRIMES;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRstart,
        StIssue,
        StWait,
        StFin
    } csidh_state_e;

endpackage

// File: rtl/csidh_exp_decode.sv
// Decodes one signed exponent nibble into magnitude, sign and a range flag.
module csidh_exp_decode
    import csidh_pkg::*;
(
    input  logic [EXP_W-1:0] i_exp,
    output logic [2:0]       o_abs,
    output logic             o_neg,
    output logic             o_in_range
);

    logic [EXP_W-1:0] w_mag;

    assign o_neg      = i_exp[EXP_W-1];
    // -8 decodes to magnitude 8, which the range test rejects.
    assign w_mag      = o_neg ? (~i_exp + EXP_W'(1)) : i_exp;
    assign o_abs      = w_mag[2:0];
    assign o_in_range = (w_mag <= EXP_W'(MAX_E));

endmodule

// File: rtl/csidh_exponent_scheduler.sv
// Key-independent command sequencer for the CSIDH group action: NUM_PRIMES*MAX_E
// commands per run, round-major, each tagged real or dummy.
module csidh_exponent_scheduler
    import csidh_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_private,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_invalid,
    output logic             o_round_start,
    output logic             o_cmd_valid,
    input  logic             i_cmd_ready,
    output logic [IDX_W-1:0] o_cmd_prime_idx,
    output logic             o_cmd_dir,
    output logic             o_cmd_dummy,
    output logic             o_cmd_last,
    input  logic             i_iso_done
);

    csidh_state_e     r_state, w_state_nxt;
    logic [KEY_W-1:0] r_key;
    logic             r_invalid;
    logic [RND_W-1:0] r_round;
    logic [IDX_W-1:0] r_idx;

    logic [EXP_W-1:0]      w_nib [NUM_PRIMES];
    logic [NUM_PRIMES-1:0] w_in_range;
    logic [2:0]            w_sel_abs;
    logic                  w_sel_neg;
    logic                  w_sel_ok_unused;
    logic                  w_all_ok;
    logic                  w_idx_end;
    logic                  w_last;

    // Every slot is range-checked in parallel so LOAD takes one cycle regardless of key.
    for (genvar g = 0; g < NUM_PRIMES; g++) begin : g_chk
        logic [2:0] w_abs_unused;
        logic       w_neg_unused;

        assign w_nib[g] = r_key[EXP_W*g +: EXP_W];

        csidh_exp_decode u_chk (
            .i_exp      (w_nib[g]),
            .o_abs      (w_abs_unused),
            .o_neg      (w_neg_unused),
            .o_in_range (w_in_range[g])
        );
    end

    csidh_exp_decode u_sel (
        .i_exp      (w_nib[r_idx]),
        .o_abs      (w_sel_abs),
        .o_neg      (w_sel_neg),
        .o_in_range (w_sel_ok_unused)
    );

    assign w_all_ok  = &w_in_range;
    assign w_idx_end = (r_idx == IDX_W'(NUM_PRIMES - 1));
    assign w_last    = w_idx_end && (r_round == RND_W'(MAX_E - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (i_start) w_state_nxt = StLoad;
            StLoad:   w_state_nxt = w_all_ok ? StRstart : StFin;
            StRstart: w_state_nxt = StIssue;
            StIssue:  if (i_cmd_ready) w_state_nxt = StWait;
            StWait: begin
                if (i_iso_done) begin
                    if (w_last)         w_state_nxt = StFin;
                    else if (w_idx_end) w_state_nxt = StRstart;
                    else                w_state_nxt = StIssue;
                end
            end
            StFin:    w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        o_busy          = 1'b0;
        o_done          = 1'b0;
        o_round_start   = 1'b0;
        o_cmd_valid     = 1'b0;
        o_cmd_prime_idx = '0;
        o_cmd_dir       = 1'b0;
        o_cmd_dummy     = 1'b0;
        o_cmd_last      = 1'b0;
        unique case (r_state)
            StLoad:   o_busy = 1'b1;
            StRstart: begin
                o_busy        = 1'b1;
                o_round_start = 1'b1;
            end
            StIssue: begin
                o_busy          = 1'b1;
                o_cmd_valid     = 1'b1;
                o_cmd_prime_idx = r_idx;
                o_cmd_dir       = ~w_sel_neg;
                o_cmd_dummy     = (w_sel_abs <= r_round);
                o_cmd_last      = w_last;
            end
            StWait:   o_busy = 1'b1;
            StFin:    o_done = 1'b1;
            default:  ;
        endcase
    end

    assign o_invalid = r_invalid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key     <= '0;
            r_invalid <= 1'b0;
            r_round   <= '0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_key     <= i_private;
                        r_invalid <= 1'b0;
                    end
                end
                StLoad: begin
                    if (!w_all_ok) begin
                        r_invalid <= 1'b1;
                    end else begin
                        r_round <= '0;
                        r_idx   <= '0;
                    end
                end
                StWait: begin
                    if (i_iso_done && !w_last) begin
                        if (w_idx_end) begin
                            r_idx   <= '0;
                            r_round <= r_round + 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csidh_exponent_scheduler.sv
// Scoreboard bench for csidh_exponent_scheduler: expected commands are queued at start
// and popped on every transfer; a zero-wait engine model answers each command.
module tb_csidh_exponent_scheduler;
    import csidh_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [KEY_W-1:0] priv = '0;
    logic             cmd_ready = 1'b1;
    logic             iso_done = 1'b0;
    logic             busy, done, invalid, round_start, cmd_valid;
    logic [IDX_W-1:0] cmd_prime_idx;
    logic             cmd_dir, cmd_dummy, cmd_last;

    typedef struct {
        int unsigned idx;
        bit          dir;
        bit          dummy;
        bit          last;
    } cmd_t;

    cmd_t        exp_q[$];
    int unsigned n_total = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    csidh_exponent_scheduler u_dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_private       (priv),
        .o_busy          (busy),
        .o_done          (done),
        .o_invalid       (invalid),
        .o_round_start   (round_start),
        .o_cmd_valid     (cmd_valid),
        .i_cmd_ready     (cmd_ready),
        .o_cmd_prime_idx (cmd_prime_idx),
        .o_cmd_dir       (cmd_dir),
        .o_cmd_dummy     (cmd_dummy),
        .o_cmd_last      (cmd_last),
        .i_iso_done      (iso_done)
    );

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [10:0] cmd_bits();
        return {cmd_valid, cmd_prime_idx, cmd_dir, cmd_dummy, cmd_last};
    endfunction

    function automatic logic [14:0] out_bits();
        return {busy, done, invalid, round_start, cmd_bits()};
    endfunction

    function automatic int nib_val(input logic [KEY_W-1:0] k, input int i);
        logic signed [3:0] n;
        n = k[4*i +: 4];
        return int'(n);
    endfunction

    function automatic bit key_valid(input logic [KEY_W-1:0] k);
        for (int i = 0; i < 74; i++) begin
            if (nib_val(k, i) < -5 || nib_val(k, i) > 5) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void push_expected(input logic [KEY_W-1:0] k);
        cmd_t c;
        int   v;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 74; i++) begin
                v       = nib_val(k, i);
                c.idx   = i;
                c.dir   = (v >= 0);
                c.dummy = ((v < 0 ? -v : v) <= r);
                c.last  = (r == 4 && i == 73);
                exp_q.push_back(c);
            end
        end
    endfunction

    // Called on a falling edge; returns on the falling edge after the run (or abort).
    task automatic run_key(input string name, input logic [KEY_W-1:0] key, input bit stall_en,
                           input bit perturb, input bit abort_en);
        int unsigned xfer_n = 0, rs_n = 0, busy_n = 0, valid_n = 0, done_n = 0;
        int unsigned first_valid = 0, done_cyc = 0, last_xfer = 0, cyc = 0, stall_left = 10;
        int          cur_round = -1;
        bit          pend = 1'b0, inj = 1'b0, aborted = 1'b0, exp_ok;
        logic [10:0] snap = '0;
        cmd_t        c;

        exp_ok = key_valid(key);
        exp_q.delete();
        if (exp_ok) push_expected(key);
        priv      = key;
        start     = 1'b1;
        cmd_ready = 1'b1;
        iso_done  = 1'b0;

        while (done_n == 0 && cyc < 4000 && !aborted) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (round_start) begin
                rs_n++;
                cur_round = int'(rs_n) - 1;
            end
            if (busy) busy_n++;
            if (cmd_valid) begin
                valid_n++;
                if (first_valid == 0) first_valid = cyc;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            iso_done  = pend;
            pend      = 1'b0;
            cmd_ready = 1'b1;
            // Start while the DUT sits in WAIT must be ignored.
            if (perturb && iso_done && xfer_n == 100) begin
                start = 1'b1;
                priv  = ~key;
            end
            if (cmd_valid) begin
                if (stall_en && cmd_prime_idx == 3 && cur_round == 2 && stall_left > 0) begin
                    cmd_ready = 1'b0;
                    if (stall_left == 10) snap = cmd_bits();
                    else check_eq({name, "_stall_hold"}, cmd_bits(), snap);
                    stall_left--;
                end else if (perturb && !inj && cmd_prime_idx == 10 && cur_round == 1) begin
                    cmd_ready = 1'b0;
                    iso_done  = 1'b1;
                    inj       = 1'b1;
                end else begin
                    xfer_n++;
                    pend = 1'b1;
                    if (cmd_last) last_xfer = xfer_n;
                    check_eq({name, "_q_nonempty"}, exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        c = exp_q.pop_front();
                        check_eq({name, "_idx"}, cmd_prime_idx, c.idx);
                        check_eq({name, "_dir"}, cmd_dir, c.dir);
                        check_eq({name, "_dummy"}, cmd_dummy, c.dummy);
                        check_eq({name, "_last"}, cmd_last, c.last);
                    end
                end
            end
            if (abort_en && cur_round == 3 && xfer_n == 3 * 74 + 20) begin
                #2 rst_n = 1'b0;
                #1 check_eq({name, "_abort_outs"}, out_bits(), 0);
                start     = 1'b0;
                cmd_ready = 1'b1;
                iso_done  = 1'b0;
                pend      = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq({name, "_abort_quiet"}, {done, busy, cmd_valid}, 0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                aborted = 1'b1;
            end
        end

        if (!aborted) begin
            check_eq({name, "_done_seen"}, done_n, 1);
            check_eq({name, "_invalid"}, invalid, !exp_ok);
            if (exp_ok) begin
                check_eq({name, "_xfers"}, xfer_n, 370);
                check_eq({name, "_round_starts"}, rs_n, 5);
                check_eq({name, "_last_at"}, last_xfer, 370);
                check_eq({name, "_first_valid"}, first_valid, 3);
                check_eq({name, "_q_left"}, exp_q.size(), 0);
            end else begin
                check_eq({name, "_done_cyc"}, done_cyc, 2);
                check_eq({name, "_valid_cycles"}, valid_n, 0);
                check_eq({name, "_busy_cycles"}, busy_n, 1);
            end
            iso_done  = 1'b0;
            cmd_ready = 1'b1;
            @(negedge clk);
            check_eq({name, "_idle_after"}, {done, busy, cmd_valid}, 0);
            check_eq({name, "_invalid_held"}, invalid, !exp_ok);
        end
    endtask

    initial begin
        logic [KEY_W-1:0] k_zero, k_mix, k_bad6, k_bad8, k_rand;
        k_zero        = '0;
        k_mix         = '0;
        k_mix[3:0]    = 4'h1;
        k_mix[23:20]  = 4'hB;
        k_bad6        = '0;
        k_bad6[11:8]  = 4'h6;
        k_bad8        = '0;
        k_bad8[295:292] = 4'h8;
        for (int i = 0; i < 74; i++) begin
            k_rand[4*i +: 4] = 4'($urandom_range(10, 0) - 5);
        end

        repeat (2) @(negedge clk);
        check_eq("reset_outs", out_bits(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_outs", out_bits(), 0);

        run_key("zero", k_zero, 1'b0, 1'b0, 1'b0);
        run_key("mixed", k_mix, 1'b0, 1'b0, 1'b0);
        run_key("bad6", k_bad6, 1'b0, 1'b0, 1'b0);
        run_key("bad8", k_bad8, 1'b0, 1'b0, 1'b0);
        run_key("stall", k_mix, 1'b1, 1'b0, 1'b0);
        run_key("perturb", k_mix, 1'b0, 1'b1, 1'b0);
        run_key("abort", k_mix, 1'b0, 1'b0, 1'b1);
        run_key("after_abort", k_zero, 1'b0, 1'b0, 1'b0);
        run_key("rand", k_rand, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
